// File: rtl/multichannel_uart_framer_if.sv
// Sample-in / byte-out bus of multichannel_uart_framer.
// master = sample source plus FIFO side (bench), slave = framer.
interface multichannel_uart_framer_if #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned DATA_W = 32
);
    logic [NCH*DATA_W-1:0] data_i;
    logic                  valid_i;
    logic                  uart_fifo_full_i;
    logic [7:0]            uart_data_o;
    logic                  uart_wr_en_o;
    logic                  busy_o;
    logic [15:0]           drop_cnt_o;

    modport master (
        output data_i, valid_i, uart_fifo_full_i,
        input  uart_data_o, uart_wr_en_o, busy_o, drop_cnt_o
    );

    modport slave (
        input  data_i, valid_i, uart_fifo_full_i,
        output uart_data_o, uart_wr_en_o, busy_o, drop_cnt_o
    );
endinterface

// File: rtl/multichannel_uart_framer.sv
// Packs an NCH-channel sample into a sync/seq/payload byte frame for the UART TX FIFO.
// Define FRAMER_CKSUM_EN to append an XOR checksum byte (seq ^ payload) to every frame.
module multichannel_uart_framer #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned DATA_W    = 32,
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input logic                      clk,
    input logic                      rst,
    multichannel_uart_framer_if.slave bus
);
    localparam int unsigned NBYTES  = (DATA_W + 7) / 8;
    localparam int unsigned CH_BITS = NBYTES * 8;
    localparam int unsigned NTOT    = NCH * NBYTES;
    localparam int unsigned IDX_W   = (NTOT > 1) ? $clog2(NTOT) : 1;
    localparam int unsigned NSLOT   = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTOT - 1);

    typedef enum logic [2:0] {
        IDLE, SYNC0, SYNC1, SEQ,
`ifdef FRAMER_CKSUM_EN
        PAYLOAD, CKSUM
`else
        PAYLOAD
`endif
    } state_t;

    state_t                state, state_nxt;
    logic [NCH*DATA_W-1:0] active, pend;
    logic                  pend_valid;
    logic [IDX_W-1:0]      idx;
    logic [7:0]            seq, frame_seq;
    logic [15:0]           drop_cnt;
    logic [CH_BITS-1:0]    ext;
    logic [7:0]            pay_bytes [NSLOT];
    logic                  wr, last, start;

    // Flattened payload, ch0 first, each channel sign-extended and MSB byte first
    always_comb begin
        ext = '0;
        for (int unsigned s = 0; s < NSLOT; s++) pay_bytes[s] = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            ext = CH_BITS'(signed'(active[k*DATA_W +: DATA_W]));
            for (int unsigned b = 0; b < NBYTES; b++)
                pay_bytes[IDX_W'(k*NBYTES + b)] = ext[(NBYTES-1-b)*8 +: 8];
        end
    end

`ifdef FRAMER_CKSUM_EN
    logic [7:0] cksum;
    always_comb begin
        cksum = frame_seq;
        for (int unsigned s = 0; s < NSLOT; s++) cksum = cksum ^ pay_bytes[s];
    end
`endif

    always_comb begin
        wr = (state != IDLE) && !bus.uart_fifo_full_i;
`ifdef FRAMER_CKSUM_EN
        last = wr && (state == CKSUM);
`else
        last = wr && (state == PAYLOAD) && (idx == LAST_IDX);
`endif
        start = ((state == IDLE) && bus.valid_i) || (last && (pend_valid || bus.valid_i));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.valid_i) state_nxt = SYNC0;
            SYNC0:   if (wr) state_nxt = SYNC1;
            SYNC1:   if (wr) state_nxt = SEQ;
            SEQ:     if (wr) state_nxt = PAYLOAD;
            PAYLOAD: begin
`ifdef FRAMER_CKSUM_EN
                if (wr && idx == LAST_IDX) state_nxt = CKSUM;
`endif
            end
            default: state_nxt = state;
        endcase
        if (last) state_nxt = (pend_valid || bus.valid_i) ? SYNC0 : IDLE;
    end

    always_comb begin
        bus.uart_wr_en_o = wr;
        bus.busy_o       = (state != IDLE);
        bus.drop_cnt_o   = drop_cnt;
        case (state)
            SYNC0:   bus.uart_data_o = SYNC_WORD[15:8];
            SYNC1:   bus.uart_data_o = SYNC_WORD[7:0];
            SEQ:     bus.uart_data_o = frame_seq;
            PAYLOAD: bus.uart_data_o = pay_bytes[idx];
`ifdef FRAMER_CKSUM_EN
            CKSUM:   bus.uart_data_o = cksum;
`endif
            default: bus.uart_data_o = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active     <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            idx        <= '0;
            seq        <= '0;
            frame_seq  <= '0;
            drop_cnt   <= '0;
        end else begin
            if (start) begin
                active    <= (state != IDLE && pend_valid) ? pend : bus.data_i;
                frame_seq <= seq;
                seq       <= seq + 8'd1;
                idx       <= '0;
            end else if (state == PAYLOAD && wr && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end
            // On the final write the pending slot is freed first, so a same-cycle valid refills it
            if (last) begin
                pend_valid <= pend_valid && bus.valid_i;
                if (pend_valid && bus.valid_i) pend <= bus.data_i;
            end else if (state != IDLE && bus.valid_i) begin
                if (!pend_valid) begin
                    pend       <= bus.data_i;
                    pend_valid <= 1'b1;
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_multichannel_uart_framer.sv
// Scoreboard bench for multichannel_uart_framer: 2x32 instance (a) and 1x12 instance (b).
module tb_multichannel_uart_framer;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    multichannel_uart_framer_if #(.NCH(2), .DATA_W(32)) ia ();
    multichannel_uart_framer_if #(.NCH(1), .DATA_W(12)) ib ();

    multichannel_uart_framer #(.NCH(2), .DATA_W(32), .SYNC_WORD(16'hA55A)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ia.slave));
    multichannel_uart_framer #(.NCH(1), .DATA_W(12), .SYNC_WORD(16'hA55A)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ib.slave));

`ifdef FRAMER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int LA = CK ? 12 : 11;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one expected byte
    always @(negedge clk) begin
        if (ia.uart_wr_en_o === 1'b1) begin
            if (exp_a.size() == 0) check("a_extra_byte", 32'(ia.uart_data_o), 32'hFFFF_FFFF);
            else check("a_byte", 32'(ia.uart_data_o), 32'(exp_a.pop_front()));
        end
        if (ib.uart_wr_en_o === 1'b1) begin
            if (exp_b.size() == 0) check("b_extra_byte", 32'(ib.uart_data_o), 32'hFFFF_FFFF);
            else check("b_byte", 32'(ib.uart_data_o), 32'(exp_b.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame_a(input logic [7:0] s, input logic [31:0] c0, input logic [31:0] c1,
                                input logic [7:0] ck);
        exp_a.push_back(8'hA5); exp_a.push_back(8'h5A); exp_a.push_back(s);
        for (int i = 3; i >= 0; i--) exp_a.push_back(c0[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) exp_a.push_back(c1[i*8 +: 8]);
        if (CK) exp_a.push_back(ck);
    endtask

    task automatic push_frame_b(input logic [7:0] s, input logic [7:0] hi, input logic [7:0] lo,
                                input logic [7:0] ck);
        exp_b.push_back(8'hA5); exp_b.push_back(8'h5A); exp_b.push_back(s);
        exp_b.push_back(hi); exp_b.push_back(lo);
        if (CK) exp_b.push_back(ck);
    endtask

    task automatic drain(input bit sel, input string name);
        int unsigned n = 0;
        while (n < 400 && (sel ? (exp_b.size() != 0 || ib.busy_o)
                               : (exp_a.size() != 0 || ia.busy_o))) begin
            tick();
            n++;
        end
        check(name, 32'(n < 400), 32'd1);
    endtask

    // Counts write cycles on instance a until busy falls
    task automatic count_run_a(output int n);
        int guard = 0;
        n = 0;
        @(negedge clk);
        while (ia.busy_o && guard < 200) begin
            if (ia.uart_wr_en_o) n++;
            guard++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [11:0] v;
        rst_a = 1'b1; rst_b = 1'b1;
        ia.data_i = '0; ia.valid_i = 1'b0; ia.uart_fifo_full_i = 1'b0;
        ib.data_i = '0; ib.valid_i = 1'b0; ib.uart_fifo_full_i = 1'b0;
        repeat (3) tick();
        check("rst_busy_a", 32'(ia.busy_o), 32'd0);
        check("rst_wr_a",   32'(ia.uart_wr_en_o), 32'd0);
        check("rst_data_a", 32'(ia.uart_data_o), 32'd0);
        check("rst_drop_a", 32'(ia.drop_cnt_o), 32'd0);
        check("rst_wr_b",   32'(ib.uart_wr_en_o), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Basic frame
        push_frame_a(8'h00, 32'hAABBCCDD, 32'h11223344, 8'h44);
        ia.data_i = {32'h11223344, 32'hAABBCCDD}; ia.valid_i = 1'b1;
        tick();
        ia.valid_i = 1'b0;
        count_run_a(n);
        check("t1_run", 32'(n), 32'(LA));
        check("t1_left", 32'(exp_a.size()), 32'd0);
        tick();

        // Backpressure on byte CC
        push_frame_a(8'h01, 32'hAABBCCDD, 32'h11223344, 8'h45);
        ia.data_i = {32'h11223344, 32'hAABBCCDD}; ia.valid_i = 1'b1;
        tick();
        ia.valid_i = 1'b0;
        n = 0;
        while (n < 20 && !(ia.busy_o && ia.uart_data_o == 8'hCC)) begin
            tick();
            n++;
        end
        check("t2_reach_cc", 32'(n < 20), 32'd1);
        ia.uart_fifo_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_wr_held", 32'(ia.uart_wr_en_o), 32'd0);
            check("t2_data_held", 32'(ia.uart_data_o), 32'hCC);
            tick();
        end
        ia.uart_fifo_full_i = 1'b0;
        drain(1'b0, "t2_drain");

        // Overflow: S0, S1 back-to-back, S2 dropped
        push_frame_a(8'h02, 32'h00000001, 32'h00000002, 8'h01);
        push_frame_a(8'h03, 32'h000000F0, 32'hFFFFFFFF, 8'hF3);
        ia.data_i = {32'h00000002, 32'h00000001}; ia.valid_i = 1'b1;
        tick();
        ia.data_i = {32'hFFFFFFFF, 32'h000000F0};
        tick();
        ia.data_i = {32'h9ABCDEF0, 32'h12345678};
        tick();
        ia.valid_i = 1'b0;
        count_run_a(n);
        check("t3_run", 32'(n), 32'(2*LA - 2));
        check("t3_drop", 32'(ia.drop_cnt_o), 32'd1);
        check("t3_left", 32'(exp_a.size()), 32'd0);
        tick();

        // Reset mid-payload with a sample pending
        exp_a.push_back(8'hA5); exp_a.push_back(8'h5A); exp_a.push_back(8'h04); exp_a.push_back(8'hDE);
        ia.data_i = {32'h01020304, 32'hDEADBEEF}; ia.valid_i = 1'b1;
        tick();
        ia.data_i = {32'h00000000, 32'h00000055};
        tick();
        ia.valid_i = 1'b0;
        tick();
        tick();
        check("t6_busy_pre", 32'(ia.busy_o), 32'd1);
        check("t6_data_pre", 32'(ia.uart_data_o), 32'hDE);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        @(negedge clk);
        check("t6_wr", 32'(ia.uart_wr_en_o), 32'd0);
        check("t6_busy", 32'(ia.busy_o), 32'd0);
        check("t6_drop", 32'(ia.drop_cnt_o), 32'd0);
        repeat (6) tick();
        check("t6_flushed", 32'(exp_a.size()), 32'd0);
        push_frame_a(8'h00, 32'h00000000, 32'h00000080, 8'h80);
        ia.data_i = {32'h00000080, 32'h00000000}; ia.valid_i = 1'b1;
        tick();
        ia.valid_i = 1'b0;
        drain(1'b0, "t6_drain");
        repeat (4) tick();

        // Sign extension, 12-bit single channel
        push_frame_b(8'h00, 8'hF8, 8'h00, 8'hF8);
        ib.data_i = 12'h800; ib.valid_i = 1'b1;
        tick();
        ib.valid_i = 1'b0;
        drain(1'b1, "t4_neg_drain");
        push_frame_b(8'h01, 8'h00, 8'h7F, 8'h7E);
        ib.data_i = 12'h07F; ib.valid_i = 1'b1;
        tick();
        ib.valid_i = 1'b0;
        drain(1'b1, "t4_pos_drain");

        // Sequence wrap over 257 spaced frames
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        tick();
        for (int i = 0; i < 257; i++) begin
            v = 12'(i);
            push_frame_b(8'(i), {4'h0, v[11:8]}, v[7:0], 8'(i) ^ {4'h0, v[11:8]} ^ v[7:0]);
            ib.data_i = v; ib.valid_i = 1'b1;
            tick();
            ib.valid_i = 1'b0;
            drain(1'b1, "t5_drain");
            tick();
        end
        check("t5_drop", 32'(ib.drop_cnt_o), 32'd0);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
